// File: rtl/neuron_pkg.sv
// neuron_pkg: shared defaults, accumulator sizing and FSM state type for neuron_ctrl
package neuron_pkg;
  localparam int DW_DEF = 8;
  localparam int N_INPUTS_DEF = 4;
  localparam int SHIFT_DEF = 6;
  typedef enum logic [1:0] {ACC, ACT, OUT} state_t;
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/neuron_mac_unit.sv
// mac_unit: signed multiply-accumulate with synchronous clear
module mac_unit #(
  parameter int DW = 8,
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);
  always_ff @(posedge clk)
    if (rst || clr) acc <= '0;
    else if (en) acc <= acc + AW'(a) * AW'(b);
endmodule

// File: rtl/neuron_ctrl.sv
// neuron_ctrl: streams x elements through a weighted sum, adds bias, applies ReLU and saturation
module neuron_ctrl
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int DW = DW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  localparam int IW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_we,
  input  logic [IW-1:0]        w_addr,
  input  logic signed [DW-1:0] w_data,
  input  logic                 b_we,
  input  logic signed [DW-1:0] b_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [DW-1:0] x_data,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic signed [DW-1:0] y_data
);
  localparam int AW = acc_w(DW, N_INPUTS);
  localparam int SW = AW + 1;
  localparam logic signed [DW-1:0] YMAX = {1'b0, {(DW-1){1'b1}}};
  state_t state, state_d;
  logic [IW-1:0] idx;
  logic signed [DW-1:0] w [N_INPUTS];
  logic signed [DW-1:0] bias, wsel, y_next;
  logic signed [AW-1:0] acc;
  logic signed [SW-1:0] s, r;
  logic x_hs, last, clr;
  assign x_hs = x_ready && x_valid;
  assign last = idx == IW'(N_INPUTS - 1);
  assign clr = state == OUT && y_ready;
  always_comb begin
    x_ready = state == ACC;
    y_valid = state == OUT;
    state_d = state == ACC ? (x_hs && last ? ACT : ACC) :
              state == ACT ? OUT : (y_ready ? ACC : OUT);
    wsel = '0;
    for (int i = 0; i < N_INPUTS; i++)
      if (idx == IW'(i)) wsel = w[i];
  end
  // bias is aligned to the Q.SHIFT product scale before the sum
  always_comb begin
    s = SW'(acc) + (SW'(bias) <<< SHIFT);
    r = s >>> SHIFT;
    y_next = s < 0 ? '0 : (r > SW'(YMAX) ? YMAX : r[DW-1:0]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ACC;
      idx <= '0;
      bias <= '0;
      y_data <= '0;
      for (int i = 0; i < N_INPUTS; i++) w[i] <= '0;
    end else begin
      state <= state_d;
      if (x_hs) idx <= last ? '0 : idx + 1'b1;
      if (b_we) bias <= b_data;
      for (int i = 0; i < N_INPUTS; i++)
        if (w_we && w_addr == IW'(i)) w[i] <= w_data;
      if (state == ACT) y_data <= y_next;
    end
  mac_unit #(.DW(DW), .AW(AW)) u_mac (
    .clk(clk), .rst(rst), .en(x_hs), .clr(clr), .a(x_data), .b(wsel), .acc(acc)
  );
endmodule

// File: tb/tb_neuron_ctrl.sv
// tb_neuron_ctrl: scoreboard bench for neuron_ctrl with latency, stall, reset and write-ordering checks
module tb_neuron_ctrl;
  logic clk = 0, rst = 1;
  logic w_we = 0, b_we = 0, x_valid = 0, y_ready = 1;
  logic [1:0] w_addr = 0;
  logic signed [7:0] w_data = 0, b_data = 0, x_data = 0;
  logic x_ready, y_valid;
  logic signed [7:0] y_data;
  int checks = 0, errors = 0;
  int q[$];
  int wm[4] = '{0, 0, 0, 0};
  int bm = 0;
  int e, held;
  always #5 clk = ~clk;
  neuron_ctrl dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_data(b_data), .x_valid(x_valid), .x_ready(x_ready),
    .x_data(x_data), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model(input int a, input int b, input int c, input int d);
    int sum = a * wm[0] + b * wm[1] + c * wm[2] + d * wm[3] + bm * 64;
    if (sum < 0) return 0;
    return sum / 64 > 127 ? 127 : sum / 64;
  endfunction
  always @(negedge clk)
    if (y_valid && y_ready) begin
      if (q.size() == 0) chk("unexpected_y", 1, 0);
      else begin
        e = q.pop_front();
        chk("y_data", int'(y_data), e);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_w(input int i, input int v);
    w_we = 1; w_addr = 2'(i); w_data = 8'(v);
    tick();
    w_we = 0;
    wm[i] = v;
  endtask
  task automatic set_all(input int v, input int b);
    for (int i = 0; i < 4; i++) set_w(i, v);
    b_we = 1; b_data = 8'(b);
    tick();
    b_we = 0;
    bm = b;
  endtask
  task automatic send_x(input int v);
    bit ok = 0;
    x_valid = 1; x_data = 8'(v);
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = x_ready;
      tick();
    end
    if (!ok) chk("x_timeout", 0, 1);
  endtask
  task automatic send_vec(input int a, input int b, input int c, input int d,
                          input bit lat, input bit bact, input int nb);
    q.push_back(model(a, b, c, d));
    send_x(a); send_x(b); send_x(c); send_x(d);
    x_valid = 0;
    if (bact) begin
      b_we = 1; b_data = 8'(nb);
      tick();
      b_we = 0;
      bm = nb;
    end else if (lat) begin
      @(negedge clk) chk("lat_e1_low", y_valid, 0);
      @(negedge clk) chk("lat_e2_high", y_valid, 1);
      @(negedge clk) chk("one_cycle", y_valid, 0);
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", int'(y_data), 0);
    tick();
    set_all(64, 0);
    send_vec(10, 20, 30, 40, 1, 0, 0);
    set_all(64, 5);
    send_vec(10, 20, 30, 40, 1, 0, 0);
    set_all(64, 0);
    send_vec(-10, -10, -10, -10, 0, 0, 0);
    set_all(127, 0);
    send_vec(127, 127, 127, 127, 0, 0, 0);
    set_all(64, 0);
    // stall in OUT: output must hold and no input accepted
    y_ready = 0;
    send_vec(1, 2, 3, 4, 0, 0, 0);
    for (int n = 0; n < 20 && !y_valid; n++) @(negedge clk);
    chk("stall_reach_out", y_valid, 1);
    held = int'(y_data);
    chk("stall_value", held, 10);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_y_valid", y_valid, 1);
      chk("stall_y_data", int'(y_data), held);
      chk("stall_x_ready", x_ready, 0);
    end
    tick();
    y_ready = 1;
    send_vec(10, 20, 30, 40, 0, 0, 0);
    tick(); tick();
    // same-edge write of the weight in use: product keeps old weight
    q.push_back(model(10, 20, 30, 40));
    w_we = 1; w_addr = 0; w_data = 0;
    send_x(10);
    w_we = 0; wm[0] = 0;
    send_x(20); send_x(30); send_x(40);
    x_valid = 0;
    tick(); tick(); tick();
    send_vec(10, 20, 30, 40, 0, 1, 100);
    tick(); tick(); tick();
    send_vec(1, 1, 1, 1, 0, 0, 0);
    tick(); tick(); tick();
    set_all(64, 0);
    // reset mid-vector with coincident writes and x handshake
    send_x(10); send_x(20);
    rst = 1; w_we = 1; w_addr = 0; w_data = 50; b_we = 1; b_data = 7; x_data = 99;
    tick();
    rst = 0; w_we = 0; b_we = 0; x_valid = 0;
    for (int i = 0; i < 4; i++) wm[i] = 0;
    bm = 0;
    @(negedge clk);
    chk("mid_rst_x_ready", x_ready, 1);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_y_data", int'(y_data), 0);
    tick();
    send_vec(10, 20, 30, 40, 1, 0, 0);
    set_all(64, 0);
    send_vec(10, 20, 30, 40, 1, 0, 0);
    for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
